// File: rtl/parity5_rx_if.sv
// parity5_rx_if: serial input and decoded frame output bundle for parity5_rx
interface parity5_rx_if #(parameter int CNT_W = 8);
   logic sin;
   logic sin_valid;
   logic clr_cnt;
   logic [4:0] out_data;
   logic out_valid;
   logic par_err;
   logic frame_err;
   logic [CNT_W-1:0] err_count;
   logic busy;
   modport master(output sin, sin_valid, clr_cnt, input out_data, out_valid, par_err, frame_err, err_count, busy);
   modport slave(input sin, sin_valid, clr_cnt, output out_data, out_valid, par_err, frame_err, err_count, busy);
endinterface

// File: rtl/parity5_rx.sv
// parity5_rx: start/5 data/parity/stop serial frame receiver with saturating error counter
module parity5_rx #(
   parameter bit ODD = 1'b0,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst,
   parity5_rx_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [2:0] bit_cnt;
   logic [4:0] data;
   logic par, stp, done, err;
   assign err = (^data ^ par ^ ODD) | ~stp;
   // frame FSM with captures; a completed frame is published one edge after its stop sample
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         bit_cnt <= '0;
         data <= '0;
         par <= 1'b0;
         stp <= 1'b0;
         done <= 1'b0;
         bus.busy <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.par_err <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.err_count <= '0;
      end else begin
         done <= 1'b0;
         bus.out_valid <= done;
         if (done) begin
            bus.out_data <= data;
            bus.par_err <= ^data ^ par ^ ODD;
            bus.frame_err <= ~stp;
         end
         bus.err_count <= bus.clr_cnt ? '0 : (done && err && ~&bus.err_count) ? bus.err_count + 1'b1 : bus.err_count;
         if (bus.sin_valid)
            case (state)
               IDLE: if (!bus.sin) begin
                  state <= DATA;
                  bit_cnt <= '0;
                  bus.busy <= 1'b1;
               end
               DATA: begin
                  data[bit_cnt] <= bus.sin;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd4) state <= PARITY;
               end
               PARITY: begin
                  par <= bus.sin;
                  state <= STOP;
               end
               default: begin
                  stp <= bus.sin;
                  done <= 1'b1;
                  state <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
      end
endmodule

// File: doc/parity5_rx.md
PARITY5_RX -- requirements
Module: parity5_rx

Interface
REQ-001 Parameter ODD, default 0, parity sense: 0 means the parity bit equals XOR of the 5 data bits; 1 means it equals the inverse of that XOR.
REQ-002 Parameter CNT_W, default 8, width of the error counter.
REQ-003 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port sin, input, 1, serial line bit; sampled only when sin_valid=1.
REQ-006 Port sin_valid, input, 1, qualifies sin; when 0, the FSM holds its state.
REQ-007 Port clr_cnt, input, 1, synchronous clear of err_count.
REQ-008 Port out_data, output, 5, received data word; bit 0 is the first data bit received.
REQ-009 Port out_valid, output, 1, one-cycle pulse marking out_data and the flags valid.
REQ-010 Port par_err, output, 1, parity mismatch for the current out_valid word.
REQ-011 Port frame_err, output, 1, stop bit sampled as 0 for the current word.
REQ-012 Port err_count, output, CNT_W, saturating count of erroneous frames.
REQ-013 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 Frame format: start bit (0), then 5 data bits LSB first, then 1 parity bit, then stop bit (1); 8 qualified samples in total.
REQ-015 FSM states are IDLE, DATA, PARITY and STOP; transitions happen only on cycles with sin_valid=1.
REQ-016 IDLE: a sample with sin=0 moves to DATA with bit_cnt=0; a sample with sin=1 stays in IDLE (line idle).
REQ-017 DATA: each sample shifts into data bit position bit_cnt and increments bit_cnt; after the sample at bit_cnt=4, go to PARITY.
REQ-018 PARITY: capture the sample as the parity bit and go to STOP.
REQ-019 STOP: capture the sample as the stop bit and go to IDLE.
REQ-020 On the next clock edge, the block registers:
- out_valid=1 for exactly one cycle
- out_data = the 5 captured data bits
- par_err = (XOR(data) ^ parity ^ ODD)
- frame_err = ~stop
REQ-021 Latency: out_valid rises on the clk edge directly after the edge that samples the stop bit.
REQ-022 out_data, par_err and frame_err hold their values until the next out_valid; they are not cleared when out_valid falls.
REQ-023 The receiver is never held off: a start bit may be sampled in the same cycle that out_valid is high (back-to-back frames).
REQ-024 A frame is erroneous when par_err or frame_err is 1; such a frame increments err_count by 1 in the same edge that asserts out_valid.
REQ-025 err_count saturates at 2^CNT_W-1; further errors leave it unchanged.
REQ-026 clr_cnt=1 sets err_count to 0 on the next edge; if it coincides with an increment, the clear wins and the result is 0.
REQ-027 A frame with frame_err=1 is still delivered with out_valid; there is no resynchronisation beyond returning to IDLE.
REQ-028 sin_valid=0 mid-frame stalls the FSM, bit_cnt and captured bits indefinitely without loss.
REQ-029 busy is a registered decode of state, equal to (state != IDLE).

Reset
REQ-030 While rst=1, the FSM is in IDLE and the following are 0: bit_cnt, the data/parity/stop captures, out_data, out_valid, par_err, frame_err, err_count and busy.
REQ-031 Reset asserted mid-frame discards the partial frame; no out_valid is produced for it, and after release the block waits for a new start bit.
REQ-032 Reset takes effect asynchronously; its release is synchronous to clk.

Verification
REQ-033 Good frame, ODD=0, data 5'b10110, sin sequence 0,0,1,1,0,1,1,1 (start, d0..d4, parity=1, stop) -> out_valid one cycle later with out_data=5'b10110, par_err=0, frame_err=0, err_count=0.
REQ-034 Same frame with parity bit 0 -> par_err=1, frame_err=0, err_count=1; the same frame with stop bit 0 and correct parity -> frame_err=1, err_count=2.
REQ-035 Good frame sent with sin_valid toggled 1,0,1,0 on every sample -> result identical to REQ-033, with out_valid one edge after the stop sample.
REQ-036 Two back-to-back frames 5'b00001 then 5'b11111 with no idle samples between them -> two out_valid pulses exactly 8 sample-cycles apart, both with par_err=0.
REQ-037 CNT_W=2, five parity-error frames -> err_count goes 1,2,3,3,3; clr_cnt asserted on the same edge as an error -> err_count=0.
REQ-038 rst pulsed after the 3rd data bit, then a full good frame -> no out_valid for the partial frame, exactly one for the good frame, and busy=0 during reset.
